// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: the {pc, inst} entry carried
// through the fetch buffers.
package fetch_pkg;

    localparam int ILEN = 32;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that empties it in one cycle.
// Push while full is accepted only together with a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       pop_data,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero before any push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: owns the PC, issues in-order word reads under a
// credit limit, buffers responses for decode and squashes on redirect.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_raw,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [31:0]      pc;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   in_use;
    logic             req_fire;
    logic             tag_full;
    logic             tag_empty;
    logic             tag_push;
    logic             tag_pop;
    fetch_entry_t     tag_in;
    fetch_entry_t     tag_head;
    logic             buf_full;
    logic             buf_empty;
    logic             buf_push;
    logic             buf_pop;
    fetch_entry_t     buf_in;
    fetch_entry_t     buf_head;

    // Credits cover both in-flight requests and buffered words, so a response
    // always has a free buffer slot waiting for it.
    assign in_use         = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = !redirect_valid && (in_use < (CNT_W + 1)'(BUF_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign tag_push = req_fire && !tag_full;
    assign tag_pop  = imem_rsp_valid && !tag_empty;
    assign tag_in   = '{pc: pc, inst: '0};

    assign buf_pop  = inst_valid && inst_ready && !redirect_valid;
    assign buf_push = imem_rsp_valid && !redirect_valid && (drop_cnt == '0)
                      && (!buf_full || buf_pop);

    always_comb begin
        buf_in      = tag_head;
        buf_in.inst = imem_rsp_data;
    end

    assign inst_valid = !buf_empty;
    assign inst_raw   = buf_head.inst;
    assign inst_pc    = buf_head.pc;

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_tag_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .push      (tag_push),
        .push_data (tag_in),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .pop_data  (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Redirect wins over everything: every response still owed by memory for
    // the old stream is counted off and discarded as it arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a queue-level reference of the fetch stream plus an
// in-order memory with programmable latency, checked every cycle.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_raw;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst_raw;
    logic [31:0] w_inst_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 1;
    int cyc     = 0;
    int last_due = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mem_q [$];
    logic [31:0] m_tags [$];
    logic [31:0] m_buf [$];
    logic [31:0] m_pc = 32'h0;
    int          m_drop = 0;
    logic        m_fire;
    logic [31:0] m_t;
    logic        got;

    always #5 clk = ~clk;

    fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_raw       (inst_raw),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (1'b0),
        .imem_rsp_data  (32'h0),
        .inst_valid     (w_inst_valid),
        .inst_ready     (1'b0),
        .inst_raw       (w_inst_raw),
        .inst_pc        (w_inst_pc),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1300_0013;
    endfunction

    function automatic logic model_req();
        return !redirect_valid && ((m_tags.size() + m_buf.size()) < 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ir, input logic qr);
        @(posedge clk);
        #1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = ir;
        imem_req_ready = qr;
    endtask

    // Reference stream and memory: advances on each clock edge from the
    // inputs that were stable before it, then presents any due response.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_pc = 32'h0;
                m_tags.delete();
                m_buf.delete();
                m_drop = 0;
                mem_q.delete();
                last_due = 0;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end else begin
                cyc++;
                m_fire = model_req() && imem_req_ready;
                if (imem_rsp_valid) begin
                    checkOutput("rsp_with_request_pending", 32'(m_tags.size() != 0), 32'd1);
                end
                if (redirect_valid) begin
                    if (imem_rsp_valid && m_tags.size() != 0) begin
                        void'(m_tags.pop_front());
                    end
                    m_buf.delete();
                    m_drop = m_tags.size();
                    m_pc   = redirect_pc;
                end else begin
                    if (inst_ready && m_buf.size() != 0) begin
                        void'(m_buf.pop_front());
                    end
                    if (imem_rsp_valid && m_tags.size() != 0) begin
                        m_t = m_tags.pop_front();
                        if (m_drop > 0) begin
                            m_drop--;
                        end else begin
                            m_buf.push_back(m_t);
                        end
                    end
                    if (m_fire) begin
                        int due;
                        due = cyc + mem_lat - 1;
                        if (due <= last_due) begin
                            due = last_due + 1;
                        end
                        last_due = due;
                        m_tags.push_back(m_pc);
                        mem_q.push_back('{due: due, addr: m_pc});
                        m_pc = m_pc + 32'd4;
                    end
                end
                #1;
                if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = 32'h0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("req_valid", 32'(imem_req_valid), 32'(model_req()));
        checkOutput("req_addr", imem_req_addr, m_pc);
        checkOutput("inst_valid", 32'(inst_valid), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
            checkOutput("inst_pc", inst_pc, m_buf[0]);
            checkOutput("inst_raw", inst_raw, mem_word(m_buf[0]));
        end
    end

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst_raw", inst_raw, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
        checkOutput("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);

        @(posedge clk);
        #2 reset_n = 1'b1;

        // First fetches with single-cycle memory, including the wrap instance.
        @(negedge clk); #1;
        checkOutput("c0_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("c0_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        checkOutput("c1_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("c1_req_addr", imem_req_addr, 32'h4);
        checkOutput("c1_wrap_addr", w_req_addr, 32'h0);
        checkOutput("c1_wrap_valid", 32'(w_req_valid), 32'd1);
        @(negedge clk); #1;
        checkOutput("c2_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("c2_inst_pc", inst_pc, 32'h0);
        checkOutput("c2_inst_raw", inst_raw, 32'h1300_0013);
        checkOutput("c2_wrap_valid", 32'(w_req_valid), 32'd0);
        @(negedge clk); #1;
        checkOutput("c3_inst_pc", inst_pc, 32'h4);
        checkOutput("c3_inst_raw", inst_raw, 32'h1300_0017);
        checkOutput("c3_req_addr", imem_req_addr, 32'h8);
        repeat (8) @(posedge clk);

        // Decode stall, then release.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_inst_valid", 32'(inst_valid), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (6) @(posedge clk);

        // Memory ready toggling with three-cycle latency.
        mem_lat = 3;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'(i % 2));
        end

        // Redirect to 0x100 with two requests in flight.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #2;
            got = (m_tags.size() == 2);
        end
        checkOutput("two_outstanding_reached", 32'(got), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk); #1;
        checkOutput("redir_req_addr", imem_req_addr, 32'h100);
        checkOutput("redir_inst_valid", 32'(inst_valid), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            got = inst_valid;
        end
        checkOutput("redir_first_seen", 32'(got), 32'd1);
        checkOutput("redir_first_pc", inst_pc, 32'h100);
        checkOutput("redir_first_raw", inst_raw, 32'h1300_0113);

        // Redirect coinciding with a response and a decode pop.
        mem_lat = 1;
        repeat (6) @(posedge clk);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #2;
            got = imem_rsp_valid && (m_buf.size() != 0);
        end
        checkOutput("rsp_pop_overlap_reached", 32'(got), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk); #1;
        checkOutput("same_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("same_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("same_req_addr", imem_req_addr, 32'h200);
        repeat (8) @(posedge clk);

        // Reset in the middle of traffic.
        @(posedge clk);
        #3 reset_n = 1'b0;
        @(negedge clk); #1;
        checkOutput("midrst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("midrst_req_addr", imem_req_addr, 32'h0);
        checkOutput("midrst_inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
